// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard scancode front end.
// Events are packed as {release, extended, code[7:0]}.
package ps2_kbd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } state_t;

   localparam logic [7:0] BYTE_EXT   = 8'hE0;
   localparam logic [7:0] BYTE_BRK   = 8'hF0;
   localparam logic [7:0] BYTE_PAUSE = 8'hE1;
   localparam logic [7:0] BYTE_BAT   = 8'hAA;
   localparam logic [7:0] BYTE_ACK   = 8'hFA;
   localparam logic [7:0] BYTE_ERR0  = 8'h00;
   localparam logic [7:0] BYTE_ERR1  = 8'hFF;

   localparam int EVT_W        = 10;
   localparam int EVT_REL_BIT  = 9;
   localparam int EVT_EXT_BIT  = 8;
   localparam int EVT_CODE_LSB = 0;
   localparam int EVT_CODE_W   = 8;

   function automatic logic [EVT_W-1:0] make_evt(input logic rel, input logic ext,
                                                  input logic [EVT_CODE_W-1:0] code);
      logic [EVT_W-1:0] e;
      e = '0;
      e[EVT_REL_BIT] = rel;
      e[EVT_EXT_BIT] = ext;
      e[EVT_CODE_LSB +: EVT_CODE_W] = code;
      return e;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; pushes and pops may coincide
// at any fill level, including full.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;
   logic [AW-1:0]    rd_next;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = head_q;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_next = rd_ptr_q + AW'(1);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_next;
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
      // The head register tracks mem[rd_ptr]; bypass din when the next head is being written now.
      if (do_pop) begin
         if (count_q == CW'(1)) begin
            if (do_push) head_d = din;
         end else begin
            head_d = mem_q[rd_next];
         end
      end else if (do_push && empty) begin
         head_d = din;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scancode parser: synchronises the receiver strobe, decodes set-2 prefix
// sequences into make/break events and queues them in a FIFO.
module ps2_kbd_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int E1_SKIP    = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  key_byte,
   input  logic                        key_strobe,
   output logic [EVT_W-1:0]            evt_data,
   output logic                        evt_valid,
   input  logic                        evt_ack,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        overflow_clr,
   output logic                        bat_ok
);

   localparam int SKIP_W = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

   logic              sync1_q, sync2_q, sync3_q;
   logic              fill_q, armed_q, armed_d;
   logic              strobe_edge;
   state_t            state_q, state_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic              bat_q, bat_d;
   logic              ovf_q, ovf_d;
   logic              push;
   logic [EVT_W-1:0]  push_evt;
   logic              fifo_full, fifo_empty;

   // A strobe already high at reset release must not count; arm only after a low sample.
   assign armed_d     = armed_q || (fill_q && !sync1_q);
   assign strobe_edge = sync2_q && !sync3_q && armed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         fill_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= key_strobe;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         fill_q  <= 1'b1;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      bat_d    = bat_q;
      push     = 1'b0;
      push_evt = '0;
      if (strobe_edge) begin
         unique case (state_q)
            ST_IDLE: begin
               if (key_byte == BYTE_EXT) begin
                  state_d = ST_EXT;
               end else if (key_byte == BYTE_BRK) begin
                  state_d = ST_BRK;
               end else if (key_byte == BYTE_PAUSE) begin
                  skip_d  = SKIP_W'(E1_SKIP);
                  state_d = ST_SKIP;
               end else if (key_byte == BYTE_BAT) begin
                  bat_d = 1'b1;
               end else if (key_byte == BYTE_ACK || key_byte == BYTE_ERR0 ||
                            key_byte == BYTE_ERR1) begin
                  state_d = ST_IDLE;
               end else begin
                  push     = 1'b1;
                  push_evt = make_evt(1'b0, 1'b0, key_byte);
               end
            end
            ST_EXT: begin
               if (key_byte == BYTE_BRK) begin
                  state_d = ST_EXT_BRK;
               end else if (key_byte != BYTE_EXT) begin
                  push     = 1'b1;
                  push_evt = make_evt(1'b0, 1'b1, key_byte);
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (key_byte == BYTE_EXT) begin
                  state_d = ST_EXT_BRK;
               end else if (key_byte != BYTE_BRK) begin
                  push     = 1'b1;
                  push_evt = make_evt(1'b1, 1'b0, key_byte);
                  state_d  = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if (key_byte != BYTE_EXT && key_byte != BYTE_BRK) begin
                  push     = 1'b1;
                  push_evt = make_evt(1'b1, 1'b1, key_byte);
                  state_d  = ST_IDLE;
               end
            end
            ST_SKIP: begin
               if (skip_q <= SKIP_W'(1)) begin
                  skip_d   = '0;
                  push     = 1'b1;
                  push_evt = make_evt(1'b0, 1'b1, BYTE_PAUSE);
                  state_d  = ST_IDLE;
               end else begin
                  skip_d = skip_q - SKIP_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Set beats clear; a full FIFO with a concurrent ack accepts the push.
   always_comb begin
      ovf_d = ovf_q;
      if (push && fifo_full && !evt_ack) ovf_d = 1'b1;
      else if (overflow_clr)             ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         skip_q  <= '0;
         bat_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         bat_q   <= bat_d;
         ovf_q   <= ovf_d;
      end
   end

   sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_evt),
      .pop   (evt_ack),
      .dout  (evt_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign evt_valid = !fifo_empty;
   assign overflow  = ovf_q;
   assign bat_ok    = bat_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed scenarios plus random byte
// streams compared against a prefix-flag reference model with an event queue.
module tb_ps2_kbd_ctrl;

   localparam int DEPTH = 8;
   localparam int SKIP  = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] key_byte = 8'h00;
   logic       key_strobe = 1'b0;
   logic [9:0] evt_data;
   logic       evt_valid;
   logic       evt_ack = 1'b0;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       overflow_clr = 1'b0;
   logic       bat_ok;

   int total = 0;
   int bad   = 0;

   logic [9:0] mq[$];
   bit         m_ovf, m_bat, m_ext, m_brk;
   int         m_skip;

   always #5 clk = ~clk;

   ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .E1_SKIP(SKIP)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_byte     (key_byte),
      .key_strobe   (key_strobe),
      .evt_data     (evt_data),
      .evt_valid    (evt_valid),
      .evt_ack      (evt_ack),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .bat_ok       (bat_ok)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_ovf = 0; m_bat = 0; m_ext = 0; m_brk = 0; m_skip = 0;
   endtask

   task automatic m_push(input logic [9:0] e);
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
   endtask

   // Prefix flags accumulate until a code byte closes the sequence.
   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) m_push(10'h1E1);
      end else if (!m_ext && !m_brk) begin
         case (b)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: m_skip = SKIP;
            8'hAA: m_bat = 1;
            8'hFA, 8'h00, 8'hFF: ;
            default: m_push({2'b00, b});
         endcase
      end else begin
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            m_push({m_brk, m_ext, b});
            m_ext = 0;
            m_brk = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      m_reset();
      idle(2);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      key_byte   = b;
      key_strobe = 1'b1;
      idle(4);
      key_strobe = 1'b0;
      idle(4);
      model_byte(b);
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
      chk({tag, ".valid"}, 32'(evt_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk({tag, ".head"}, 32'(evt_data), 32'(mq[0]));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".bat"}, 32'(bat_ok), 32'(m_bat));
   endtask

   task automatic pop_check(input string tag);
      chk({tag, ".pvalid"}, 32'(evt_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk({tag, ".pdata"}, 32'(evt_data), 32'(mq[0]));
         void'(mq.pop_front());
      end
      evt_ack = 1'b1;
      @(negedge clk);
      evt_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (mq.size() != 0 && guard < 32) begin
         pop_check(tag);
         guard++;
      end
      chk({tag, ".empty"}, 32'(fifo_count), 32'd0);
   endtask

   task automatic clr_ovf();
      @(negedge clk);
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      m_ovf = 0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] seq_e1 [8];
      logic [7:0] b;
      seq_e1 = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      m_reset();
      idle(3);
      rst = 1'b0;
      idle(2);
      chk("rst.count", 32'(fifo_count), 32'd0);
      chk("rst.valid", 32'(evt_valid), 32'd0);
      chk("rst.data", 32'(evt_data), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      chk("rst.bat", 32'(bat_ok), 32'd0);

      // Latency: evt_valid rises on the third edge after the strobe is first sampled.
      @(negedge clk);
      key_byte   = 8'h1C;
      key_strobe = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("lat.edge2", 32'(evt_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat.edge3", 32'(evt_valid), 32'd1);
      @(negedge clk);
      key_strobe = 1'b0;
      idle(4);
      model_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_state("mk_brk");
      drain("mk_brk");

      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      chk("ext.head0", 32'(evt_data), 32'h175);
      check_state("ext");
      drain("ext");

      foreach (seq_e1[i]) send_byte(seq_e1[i]);
      chk("e1.count", 32'(fifo_count), 32'd1);
      chk("e1.head", 32'(evt_data), 32'h1E1);
      send_byte(8'h1C);
      check_state("e1.idle");
      drain("e1");

      pop_check("pop_empty");
      chk("pop_empty.count", 32'(fifo_count), 32'd0);

      for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
      chk("ovf.count", 32'(fifo_count), 32'd8);
      chk("ovf.flag", 32'(overflow), 32'd1);
      check_state("ovf");
      clr_ovf();
      chk("ovf.clr", 32'(overflow), 32'd0);

      // Full FIFO: ack lands in the same cycle as the push.
      @(negedge clk);
      key_byte   = 8'h2B;
      key_strobe = 1'b1;
      @(negedge clk);
      @(negedge clk);
      evt_ack = 1'b1;
      @(negedge clk);
      evt_ack = 1'b0;
      idle(2);
      key_strobe = 1'b0;
      idle(4);
      void'(mq.pop_front());
      model_byte(8'h2B);
      chk("full_pp.count", 32'(fifo_count), 32'd8);
      chk("full_pp.ovf", 32'(overflow), 32'd0);
      chk("full_pp.head", 32'(evt_data), 32'h011);
      check_state("full_pp");
      drain("full_pp");

      send_byte(8'hE0);
      do_reset();
      send_byte(8'h1C);
      chk("rst_mid.head", 32'(evt_data), 32'h01C);
      send_byte(8'hAA);
      chk("bat.flag", 32'(bat_ok), 32'd1);
      chk("bat.count", 32'(fifo_count), 32'd1);
      check_state("bat");
      drain("bat");

      // Strobe held high across reset release must not be taken as a byte.
      @(negedge clk);
      key_byte   = 8'h1C;
      key_strobe = 1'b1;
      rst        = 1'b1;
      idle(3);
      rst = 1'b0;
      m_reset();
      idle(6);
      key_strobe = 1'b0;
      idle(6);
      chk("stuck.count", 32'(fifo_count), 32'd0);
      send_byte(8'h24);
      check_state("stuck.after");
      drain("stuck");

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 11))
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
            3: b = 8'hAA;
            4: b = 8'hFA;
            5: b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
            default: b = 8'($urandom_range(0, 255));
         endcase
         send_byte(b);
         check_state($sformatf("rnd%0d", n));
         if ($urandom_range(0, 2) == 0) pop_check($sformatf("rnd%0d", n));
         if ($urandom_range(0, 19) == 0) clr_ovf();
         if ($urandom_range(0, 99) == 0) do_reset();
      end
      drain("rnd_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter E1_SKIP, default 7, meaning bytes discarded after an 0xE1 prefix.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port key_byte  input  8  received scancode byte from the PS/2 receiver; stable while key_strobe is high.
REQ-006 SHALL have port key_strobe  input  1  byte-ready pulse from the receiver; treated as asynchronous to clk.
REQ-007 SHALL have port evt_data  output  10  FIFO head event {release, extended, code[7:0]}.
REQ-008 SHALL have port evt_valid  output  1  FIFO not empty.
REQ-009 SHALL have port evt_ack  input  1  pop the head event; ignored when evt_valid=0.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored events.
REQ-011 SHALL have port overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-012 SHALL have port overflow_clr  input  1  clears overflow.
REQ-013 SHALL have port bat_ok  output  1  sticky flag: the keyboard reported self-test pass (0xAA).

Function
REQ-014 SHALL synchronize key_strobe through two flops and detect its rising edge with a third flop; each edge is exactly one byte event.
REQ-015 SHALL sample key_byte in the edge-detect cycle; the resulting FIFO write is visible, so evt_valid=1, 3 clk edges after key_strobe is first sampled high.
REQ-016 SHALL run the parser FSM with states IDLE, EXT, BRK, EXT_BRK, SKIP.
REQ-017 From IDLE: 0xE0 goes to EXT; 0xF0 goes to BRK; 0xE1 loads a skip counter with E1_SKIP and goes to SKIP; 0xAA sets bat_ok and stays in IDLE; 0xFA, 0x00 and 0xFF are dropped and the FSM stays in IDLE; any other byte pushes {0,0,byte}.
REQ-018 From EXT: 0xF0 goes to EXT_BRK; 0xE0 stays in EXT; any other byte pushes {0,1,byte} and returns to IDLE.
REQ-019 From BRK: any byte other than 0xE0/0xF0 pushes {1,0,byte} and returns to IDLE; 0xE0 goes to EXT_BRK; 0xF0 stays in BRK.
REQ-020 From EXT_BRK: any byte other than 0xE0/0xF0 pushes {1,1,byte} and returns to IDLE; 0xE0/0xF0 stay in EXT_BRK.
REQ-021 In SKIP, each byte decrements the counter; the byte that brings it to 0 pushes {0,1,0xE1} and returns to IDLE.
REQ-022 A push while the FIFO is full and evt_ack=0 SHALL drop the event, leave the FIFO unchanged and set overflow.
REQ-023 A push and a pop in the same cycle SHALL both take effect at every fill level, including full; overflow stays unchanged.
REQ-024 A pop when empty SHALL have no effect; fifo_count never wraps below 0 or above FIFO_DEPTH.
REQ-025 When overflow_clr and a new overflow occur in the same cycle, the set SHALL win.
REQ-026 evt_data SHALL be the head entry, registered, and valid whenever evt_valid=1; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 rst SHALL clear the FSM to IDLE, the skip counter, the synchronizer flops, the FIFO pointers, fifo_count=0, evt_valid=0, evt_data=0, overflow=0 and bat_ok=0.
REQ-028 Reset asserted mid-sequence (for example after 0xE0) SHALL discard the partial sequence; the first byte after reset is parsed from IDLE.
REQ-029 A key_strobe that is already high when rst deasserts SHALL NOT produce an edge; the synchronizer clears to 0 and re-samples.

Structure
REQ-030 Package ps2_kbd_pkg SHALL hold the FSM state enumeration, the byte constants (0xE0, 0xF0, 0xE1, 0xAA, 0xFA) and the event width and field positions.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (parameterised width and depth, with push, pop, full, empty and count).

Verification
REQ-032 Bytes 0x1C; 0xF0 0x1C -> events 0x01C, then 0x21C; fifo_count=2.
REQ-033 Bytes 0xE0 0x75; 0xE0 0xF0 0x75 -> events 0x175, then 0x375.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event, 0x1E1; the FSM is back in IDLE.
REQ-035 Nine make codes with no ack at FIFO_DEPTH=8 -> fifo_count=8, overflow=1, the first eight events are intact; overflow_clr then clears it.
REQ-036 With the FIFO full, a push and evt_ack in the same cycle -> count stays 8, overflow stays 0, head advances.
REQ-037 Byte 0xE0, then rst, then 0x1C -> event 0x01C, not 0x11C; byte 0xAA -> bat_ok=1 and no event.
